global_mem_ld_arbiter: RTL and testbench

- Shares the banked global memory between N_REQ processing-element load units.
- Each load unit drives addr/req and expects gnt in the same cycle, then read data exactly one cycle after gnt.
- One independent round-robin arbiter per bank, so up to N_BANKS grants per cycle.
- Sits between the PE array's load units and the global memory bank macros.

---
 rtl/pe_pkg.sv | 13 +
 rtl/rr_arbiter_1bank.sv | 49 ++++
 rtl/global_mem_ld_arbiter.sv | 125 ++++++++++++
 tb/tb_global_mem_ld_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and types for the PE array global memory path.
package pe_pkg;

  localparam int N_PE               = 16;
  localparam int GLOBAL_MEM_N_BANKS = 4;
  localparam int GLOBAL_MEM_BANK_L  = $clog2(GLOBAL_MEM_N_BANKS);
  localparam int GLOBAL_MEM_ADDR_L  = 12;
  localparam int GLOBAL_MEM_DATA_L  = 32;
  localparam int STAT_CNT_L         = 32;

  typedef logic [GLOBAL_MEM_BANK_L-1:0] bank_idx_t;

endpackage

// File: rtl/rr_arbiter_1bank.sv
// Round-robin arbiter for one global memory bank.
// Grant is combinational from the candidate vector and the internal pointer;
// the pointer moves to one past the granted requester on the next edge.
module rr_arbiter_1bank #(
  parameter int N_REQ = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] cand,
  output logic [N_REQ-1:0] gnt,
  output logic             vld
);

  localparam int PTR_L = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_L-1:0] rr_ptr;
  logic [PTR_L-1:0] gnt_idx;

  // First candidate at or after rr_ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin
    int               pos;
    logic [PTR_L-1:0] pos_idx;
    gnt     = '0;
    vld     = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    pos_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      pos = int'(rr_ptr) + off;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = PTR_L'(pos);
      if (!vld && cand[pos_idx]) begin
        gnt[pos_idx] = 1'b1;
        vld          = 1'b1;
        gnt_idx      = pos_idx;
      end
    end
  end

  // Pointer advances past the winner; holds when the bank is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (vld) begin
      rr_ptr <= (gnt_idx == PTR_L'(N_REQ-1)) ? '0 : gnt_idx + PTR_L'(1);
    end
  end

endmodule

// File: rtl/global_mem_ld_arbiter.sv
// Load arbiter between the PE load units and the banked global memory.
// One round-robin arbiter per bank, combinational grant, fixed one-cycle
// read return. Optional per-bank conflict counters under GLOBAL_ARB_STATS_EN.
module global_mem_ld_arbiter
  import pe_pkg::*;
#(
  parameter int N_REQ   = N_PE,
  parameter int N_BANKS = GLOBAL_MEM_N_BANKS,
  parameter int ADDR_L  = GLOBAL_MEM_ADDR_L,
  parameter int DATA_L  = GLOBAL_MEM_DATA_L,
  parameter int BANK_L  = $clog2(N_BANKS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ*ADDR_L-1:0]            req_addr,
  input  logic [N_REQ-1:0]                   req,
  output logic [N_REQ-1:0]                   gnt,
  output logic [N_REQ*DATA_L-1:0]            rdata,
  output logic [N_REQ-1:0]                   rdata_vld,
  output logic [N_BANKS*(ADDR_L-BANK_L)-1:0] bank_addr,
  output logic [N_BANKS-1:0]                 bank_rd_en,
  input  logic [N_BANKS*DATA_L-1:0]          bank_rdata,
  output logic [N_BANKS*STAT_CNT_L-1:0]      stat_conflict_cnt
);

  localparam int WORD_L = ADDR_L - BANK_L;

  logic [BANK_L-1:0] req_bank     [N_REQ];
  logic [WORD_L-1:0] req_word     [N_REQ];
  logic [N_REQ-1:0]  cand         [N_BANKS];
  logic [N_REQ-1:0]  bank_gnt     [N_BANKS];
  logic [N_BANKS-1:0] bank_vld;
  logic [DATA_L-1:0] bank_rdata_w [N_BANKS];
  logic [N_REQ-1:0]  gnt_q;
  logic [BANK_L-1:0] bank_q       [N_REQ];

  // Split each requester address into bank select (low bits) and word address.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bank[i] = req_addr[i*ADDR_L +: BANK_L];
      req_word[i] = req_addr[i*ADDR_L + BANK_L +: WORD_L];
    end
  end

  // Candidate vector per bank: requesting units whose address lands in it.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      cand[b] = '0;
      for (int i = 0; i < N_REQ; i++) begin
        cand[b][i] = req[i] && (req_bank[i] == BANK_L'(b));
      end
    end
  end

  for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_bank
    rr_arbiter_1bank #(.N_REQ(N_REQ)) u_arb (
      .clk  (clk),
      .rst  (rst),
      .cand (cand[gb]),
      .gnt  (bank_gnt[gb]),
      .vld  (bank_vld[gb])
    );
  end

  assign bank_rd_en = bank_vld;

  // Merge per-bank one-hot grants and steer the winner's word address to its bank.
  always_comb begin
    gnt       = '0;
    bank_addr = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bank_gnt[b][i]) begin
          gnt[i]                         = 1'b1;
          bank_addr[b*WORD_L +: WORD_L]  = req_word[i];
        end
      end
    end
  end

  // Remember who was granted and from which bank, for the data return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= '0;
      for (int i = 0; i < N_REQ; i++) bank_q[i] <= '0;
    end else begin
      gnt_q <= gnt;
      for (int i = 0; i < N_REQ; i++) bank_q[i] <= req_bank[i];
    end
  end

  // Return data: each requester reads the bank it hit one cycle earlier.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) bank_rdata_w[b] = bank_rdata[b*DATA_L +: DATA_L];
    rdata = '0;
    for (int i = 0; i < N_REQ; i++) rdata[i*DATA_L +: DATA_L] = bank_rdata_w[bank_q[i]];
  end

  assign rdata_vld = gnt_q;

`ifdef GLOBAL_ARB_STATS_EN
  logic [STAT_CNT_L-1:0] conflict_cnt [N_BANKS];

  // Count cycles with two or more candidates on a bank; saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < N_BANKS; b++) conflict_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (((cand[b] & (cand[b] - N_REQ'(1))) != '0) && (conflict_cnt[b] != '1)) begin
          conflict_cnt[b] <= conflict_cnt[b] + STAT_CNT_L'(1);
        end
      end
    end
  end

  // Flatten counters onto the stats port.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) stat_conflict_cnt[b*STAT_CNT_L +: STAT_CNT_L] = conflict_cnt[b];
  end
`else
  assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_global_mem_ld_arbiter.sv
// Directed bench for global_mem_ld_arbiter with a one-cycle bank memory model.
module tb_global_mem_ld_arbiter;

  localparam int N_REQ   = 16;
  localparam int N_BANKS = 4;
  localparam int ADDR_L  = 12;
  localparam int DATA_L  = 32;
  localparam int WORD_L  = 10;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ*ADDR_L-1:0]     req_addr;
  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ*DATA_L-1:0]     rdata;
  logic [N_REQ-1:0]            rdata_vld;
  logic [N_BANKS*WORD_L-1:0]   bank_addr;
  logic [N_BANKS-1:0]          bank_rd_en;
  logic [N_BANKS*DATA_L-1:0]   bank_rdata;
  logic [N_BANKS*32-1:0]       stat_conflict_cnt;

  int checks = 0;
  int errors = 0;

  global_mem_ld_arbiter #(
    .N_REQ(N_REQ), .N_BANKS(N_BANKS), .ADDR_L(ADDR_L), .DATA_L(DATA_L)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_addr          (req_addr),
    .req               (req),
    .gnt               (gnt),
    .rdata             (rdata),
    .rdata_vld         (rdata_vld),
    .bank_addr         (bank_addr),
    .bank_rd_en        (bank_rd_en),
    .bank_rdata        (bank_rdata),
    .stat_conflict_cnt (stat_conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int b, input int w);
    return 32'hA000_0000 | (32'(b) << 16) | 32'(w);
  endfunction

  // Bank macro model: registered read of the addressed word.
  always @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_rd_en[b]) bank_rdata[b*DATA_L +: DATA_L] <= mem_word(b, int'(bank_addr[b*WORD_L +: WORD_L]));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [11:0] a);
    req_addr[i*ADDR_L +: ADDR_L] = a;
    req[i] = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    #1;
    check("rst_vld", 64'(rdata_vld), 64'h0);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_en", 64'(bank_rd_en), 64'h0);
    check("rst_stat", 64'(stat_conflict_cnt[63:0]), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single request: requester 5, addr 0x101 -> bank 1 word 0x40
    @(negedge clk);
    drive(5, 12'h101);
    #1;
    check("single_gnt", 64'(gnt), 64'h0020);
    check("single_en", 64'(bank_rd_en), 64'h2);
    check("single_addr", 64'(bank_addr[1*WORD_L +: WORD_L]), 64'h040);
    @(posedge clk); #1;
    check("single_vld", 64'(rdata_vld), 64'h0020);
    check("single_data", 64'(rdata[5*DATA_L +: DATA_L]), 64'(mem_word(1, 'h40)));
    @(negedge clk);
    req = '0;

    // Parallel banks: requester b -> bank b, word 0x10+b; rr_ptr[1]=6 wraps to 1
    @(negedge clk);
    drive(0, 12'h040);
    drive(1, 12'h045);
    drive(2, 12'h04A);
    drive(3, 12'h04F);
    #1;
    check("par_gnt", 64'(gnt), 64'h000F);
    check("par_en", 64'(bank_rd_en), 64'hF);
    check("par_addr", 64'(bank_addr), 64'({10'h013, 10'h012, 10'h011, 10'h010}));
    @(posedge clk); #1;
    check("par_vld", 64'(rdata_vld), 64'h000F);
    check("par_data_lo", 64'(rdata[63:0]), {mem_word(1, 'h11), mem_word(0, 'h10)});
    check("par_data_hi", 64'(rdata[127:64]), {mem_word(3, 'h13), mem_word(2, 'h12)});
    @(negedge clk);
    req = '0;

    // Withdrawn request: 6 and 7 on bank 3, rr_ptr[3]=4 so 6 wins; 7 then drops
    @(negedge clk);
    drive(6, 12'h083);
    drive(7, 12'h087);
    #1;
    check("wd_gnt", 64'(gnt), 64'h0040);
    check("wd_addr", 64'(bank_addr[3*WORD_L +: WORD_L]), 64'h020);
    @(negedge clk);
    req = '0;
    #1;
    check("wd_vld", 64'(rdata_vld), 64'h0040);
    check("wd_data", 64'(rdata[6*DATA_L +: DATA_L]), 64'(mem_word(3, 'h20)));
    @(negedge clk);
    #1;
    check("wd_vld_none", 64'(rdata_vld), 64'h0);
    // rr_ptr[3] must be 7: with 6 and 7 both asking again, 7 wins
    @(negedge clk);
    drive(6, 12'h083);
    drive(7, 12'h087);
    #1;
    check("wd_ptr_gnt", 64'(gnt), 64'h0080);
    check("wd_ptr_addr", 64'(bank_addr[3*WORD_L +: WORD_L]), 64'h021);
    @(negedge clk);
    req = '0;
    #1;
    check("wd_ptr_vld", 64'(rdata_vld), 64'h0080);
    check("wd_ptr_data", 64'(rdata[7*DATA_L +: DATA_L]), 64'(mem_word(3, 'h21)));

    // Reset mid-transfer: grant 3 on bank 0 (rr_ptr[0]=1), then reset
    @(negedge clk);
    drive(3, 12'h00C);
    #1;
    check("rm_gnt", 64'(gnt), 64'h0008);
    @(posedge clk); #1;
    check("rm_vld_before", 64'(rdata_vld), 64'h0008);
    #2;
    rst = 1'b1;
    #1;
    check("rm_vld_reset", 64'(rdata_vld), 64'h0);
    @(negedge clk);
    req = '0;
    #1;
    check("rm_gnt_idle", 64'(gnt), 64'h0);
    check("rm_en_idle", 64'(bank_rd_en), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) drive(i, 12'(i << 2));
    #1;
    check("rm_all_gnt", 64'(gnt), 64'h0001);
    check("rm_all_addr", 64'(bank_addr[0 +: WORD_L]), 64'h000);
    @(negedge clk);
    req = '0;
    #1;
    check("rm_all_vld", 64'(rdata_vld), 64'h0001);
    check("rm_all_data", 64'(rdata[0 +: DATA_L]), 64'(mem_word(0, 0)));

    // Full conflict on bank 2 from rr_ptr[2]=0: grants 0..15 then 0
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) drive(i, 12'((i << 2) | 2));
    for (int k = 0; k <= 16; k++) begin
      #1;
      check($sformatf("conf_gnt_%0d", k), 64'(gnt), 64'(16'(1) << (k % 16)));
      check($sformatf("conf_en_%0d", k), 64'(bank_rd_en), 64'h4);
      check($sformatf("conf_addr_%0d", k), 64'(bank_addr[2*WORD_L +: WORD_L]), 64'(k % 16));
      if (k > 0) begin
        check($sformatf("conf_vld_%0d", k), 64'(rdata_vld), 64'(16'(1) << ((k - 1) % 16)));
        check($sformatf("conf_data_%0d", k), 64'(rdata[((k - 1) % 16)*DATA_L +: DATA_L]),
              64'(mem_word(2, (k - 1) % 16)));
      end
`ifdef GLOBAL_ARB_STATS_EN
      if (k == 15) check("conf_stat_15", 64'(stat_conflict_cnt[2*32 +: 32]), 64'd15);
`endif
      @(negedge clk);
    end
    req = '0;
    #1;
`ifdef GLOBAL_ARB_STATS_EN
    check("stat_b0", 64'(stat_conflict_cnt[0 +: 32]), 64'd1);
    check("stat_b1", 64'(stat_conflict_cnt[32 +: 32]), 64'd0);
    check("stat_b2", 64'(stat_conflict_cnt[64 +: 32]), 64'd17);
    check("stat_b3", 64'(stat_conflict_cnt[96 +: 32]), 64'd0);
`else
    check("stat_off_lo", 64'(stat_conflict_cnt[63:0]), 64'h0);
    check("stat_off_hi", 64'(stat_conflict_cnt[127:64]), 64'h0);
`endif

    // Wrap-around: grant 14 on bank 0 (rr_ptr[0]=1) leaves rr_ptr[0]=15
    @(negedge clk);
    drive(14, 12'h038);
    #1;
    check("wrap_pre_gnt", 64'(gnt), 64'h4000);
    @(negedge clk);
    req = '0;
    drive(15, 12'h03C);
    drive(0, 12'h000);
    #1;
    check("wrap_gnt_15", 64'(gnt), 64'h8000);
    check("wrap_addr_15", 64'(bank_addr[0 +: WORD_L]), 64'h00F);
    @(negedge clk);
    #1;
    check("wrap_vld_15", 64'(rdata_vld), 64'h8000);
    check("wrap_gnt_0", 64'(gnt), 64'h0001);
    check("wrap_addr_0", 64'(bank_addr[0 +: WORD_L]), 64'h000);
    @(negedge clk);
    req = '0;
    #1;
    check("wrap_vld_0", 64'(rdata_vld), 64'h0001);
    check("wrap_data_0", 64'(rdata[0 +: DATA_L]), 64'(mem_word(0, 0)));
    @(negedge clk);
    #1;
    check("idle_vld", 64'(rdata_vld), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
